registru_piso: RTL

Parallel-in, serial-out shift register with a valid/ready load handshake. It is the transmit-side counterpart of the team's 4-bit SIPO register `registru2`. It accepts a WIDTH-bit word and drives it onto a single serial line, one bit per clock, LSB first by default. With the defaults, `ser_out` wired into `registru2` reconstructs `data_in` on that block's parallel output. Back-to-back words stream with no idle gap.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 37 +++
 rtl/registru_piso.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the registru_piso serializer.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of a frame; last marks the final bit.
module piso_bit_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/registru_piso.sv
// Parallel-in serial-out shift register with valid/ready load handshake.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module registru_piso
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW      = $clog2(WIDTH);
    localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             fs_q, fs_d;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             cnt_dec;
    logic             ready_int;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    piso_bit_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (CW'(WIDTH - 1)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            fs_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            fs_q    <= fs_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            IDLE:    ready_int = 1'b1;
`ifdef PISO_PARITY_EN
            SHIFT:   ready_int = 1'b0;
            PARITY:  ready_int = 1'b1;
`else
            SHIFT:   ready_int = last;
            PARITY:  ready_int = 1'b0;
`endif
            default: ready_int = 1'b0;
        endcase
        load_ready = rst_n && ready_int;
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (last) begin
                    if (accept) begin
                        state_d = SHIFT;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            PARITY: begin
                state_d = accept ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Parity is dropped into the output position so ser_out stays a plain flop.
    always_comb begin
        sh_d    = sh_q;
        fs_d    = 1'b0;
        cnt_dec = (state_q == SHIFT) && !accept;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            sh_d = data_in;
            fs_d = 1'b1;
`ifdef PISO_PARITY_EN
            par_d = ^data_in;
`endif
        end else if (state_q == SHIFT) begin
`ifdef PISO_PARITY_EN
            if (last) begin
                sh_d          = '0;
                sh_d[OUT_IDX] = par_q;
            end else
`endif
            if (MSB_FIRST) begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end
        end else begin
            sh_d = '0;
        end
    end

    always_comb begin
        ser_out     = sh_q[OUT_IDX];
        ser_valid   = (state_q != IDLE);
        frame_start = fs_q;
        busy        = (state_q != IDLE);
    end

endmodule
